// File: rtl/bcd_to_bin_if.sv
// bcd_to_bin_if: start/busy/done request and result bundle for bcd_to_bin (master drives digits, slave returns bin/err)
interface bcd_to_bin_if #(parameter int OUT_W = 12);
  logic start;
  logic neg;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic busy;
  logic done;
  logic err;
  logic [OUT_W-1:0] bin;
  modport master (output start, neg, hundreds, tens, ones, input busy, done, err, bin);
  modport slave (input start, neg, hundreds, tens, ones, output busy, done, err, bin);
endinterface

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: signed 3-digit BCD to two's-complement via reverse double-dabble; clk, rst (async active-low), bus (slave); BCD2BIN_FAST_EN selects single-cycle multiply-add
module bcd_to_bin #(
  parameter int OUT_W = 12
) (
  input logic clk,
  input logic rst,
  bcd_to_bin_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t state;
  logic [11:0] bcd;
  logic neg_q;
  logic err_q;
  logic bad;
  logic [OUT_W-1:0] mag;
  assign bad = (bus.hundreds > 4'd9) | (bus.tens > 4'd9) | (bus.ones > 4'd9);
`ifdef BCD2BIN_FAST_EN
  localparam state_t FIRST = FINISH;
  assign mag = OUT_W'(11'(bcd[11:8]) * 11'd100 + 11'(bcd[7:4]) * 11'd10 + 11'(bcd[3:0]));
`else
  localparam state_t FIRST = SHIFT;
  logic [9:0] acc;
  logic [3:0] cnt;
  logic [11:0] sh;
  logic [11:0] adj;
  always_comb begin
    sh = bcd >> 1;
    adj = sh;
    for (int i = 0; i < 3; i++)
      adj[4*i +: 4] = sh[4*i +: 4] >= 4'd8 ? sh[4*i +: 4] - 4'd3 : sh[4*i +: 4];
  end
  assign mag = OUT_W'(acc);
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bcd <= '0;
      neg_q <= 1'b0;
      err_q <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.bin <= '0;
`ifndef BCD2BIN_FAST_EN
      acc <= '0;
      cnt <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bcd <= {bus.hundreds, bus.tens, bus.ones};
          neg_q <= bus.neg;
          err_q <= bad;
          bus.busy <= 1'b1;
          state <= FIRST;
`ifndef BCD2BIN_FAST_EN
          acc <= '0;
          cnt <= '0;
`endif
        end
`ifndef BCD2BIN_FAST_EN
        SHIFT: begin
          acc <= {bcd[0], acc[9:1]};
          bcd <= adj;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) state <= FINISH;
        end
`endif
        FINISH: begin
          bus.err <= err_q;
          bus.bin <= err_q ? '0 : neg_q ? -mag : mag;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
